// File: rtl/data_mem_ctrl_pkg.sv
// Shared constants, FSM encoding and region types
// for the data-memory front end.
package data_mem_ctrl_pkg;

  localparam logic [15:0] RAM1_UPPER_D  = 16'h8000;
  localparam logic [15:0] COM_DATA_D    = 16'hBF00;
  localparam logic [15:0] COM_STAT_D    = 16'hBF01;
  localparam logic [15:0] COM_MASK_LO_D = 16'hBF02;

  localparam int TMR_W = 4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_ACCESS  = 3'd2,
    S_TX_WAIT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    R_RAM1     = 3'd0,
    R_RAM2     = 3'd1,
    R_COM_DATA = 3'd2,
    R_COM_STAT = 3'd3,
    R_COM_RSV  = 3'd4
  } region_t;

  function automatic logic on_bus1(region_t r);
    return (r == R_RAM1) || (r == R_COM_DATA);
  endfunction

endpackage

// File: rtl/data_mem_ctrl_timer.sv
// strobe_timer: loadable down-counter; last flags
// the final strobe cycle. Ports: clk, rst, load, load_val, run, last.
module strobe_timer
  import data_mem_ctrl_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         run,
  output logic         last
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (run && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign last = (cnt_q == '0);

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory front end: req/rsp handshake to Ram1/Ram2/UART.
// Ports: req_*/rsp_* MEM side, ram*/rdn/wrn/tbre/tsre/data_ready board side.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter logic [ADDR_W-1:0] RAM1_UPPER  = ADDR_W'(RAM1_UPPER_D),
  parameter logic [ADDR_W-1:0] COM_DATA    = ADDR_W'(COM_DATA_D),
  parameter logic [ADDR_W-1:0] COM_STAT    = ADDR_W'(COM_STAT_D),
  parameter logic [ADDR_W-1:0] COM_MASK_LO = ADDR_W'(COM_MASK_LO_D),
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              addr_src,
  inout  wire  [DATA_W-1:0] ram1_data,
  inout  wire  [DATA_W-1:0] ram2_data,
  output logic              ram1_en,
  output logic              ram1_oe,
  output logic              ram1_we,
  output logic              ram2_en,
  output logic              ram2_oe,
  output logic              ram2_we,
  output logic              rdn,
  output logic              wrn,
  input  logic              tbre,
  input  logic              tsre,
  input  logic              data_ready
);

  // Reserved window runs from COM_MASK_LO to the end of its 16-word block.
  localparam logic [ADDR_W-1:0] COM_MASK_HI =
    COM_MASK_LO | ADDR_W'(4'hF);
  localparam logic [TMR_W-1:0] TMR_LOAD =
    TMR_W'(WAIT_CYCLES - 1);

  state_t  state_q, state_d;
  region_t rgn_q, rgn_d;

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              hold_q;
  logic              accept, last, sel, act, drv;
  logic              in_win, in_com;

  assign in_win = (req_addr >= COM_MASK_LO) &&
                  (req_addr <= COM_MASK_HI);
  assign in_com = in_win || (req_addr == COM_DATA) ||
                  (req_addr == COM_STAT);

  always_comb begin
    rgn_d = R_RAM2;
    unique case (1'b1)
      req_addr == COM_DATA:
        rgn_d = R_COM_DATA;
      req_addr == COM_STAT:
        rgn_d = R_COM_STAT;
      in_win:
        rgn_d = R_COM_RSV;
      !in_com && (req_addr < RAM1_UPPER):
        rgn_d = R_RAM1;
      default:
        rgn_d = R_RAM2;
    endcase
  end

  assign req_ready = (state_q == S_IDLE);
  assign accept    = req_valid && req_ready;
  assign sel = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign act = (state_q == S_ACCESS);

  strobe_timer #(.W(TMR_W)) u_tmr (
    .clk      (clk),
    .rst      (rst),
    .load     (state_q == S_SETUP),
    .load_val (TMR_LOAD),
    .run      (act),
    .last     (last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (accept)
          state_d = (rgn_d == R_COM_RSV) ? S_DONE : S_SETUP;
      S_SETUP:
        state_d = S_ACCESS;
      S_ACCESS:
        if (last)
          state_d = (we_q && rgn_q == R_COM_DATA) ?
                    S_TX_WAIT : S_DONE;
      S_TX_WAIT:
        if (tbre && tsre)
          state_d = S_DONE;
      S_DONE:
        state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rdata_d = ram1_data;
    unique case (rgn_q)
      R_RAM2: rdata_d = ram2_data;
      R_COM_STAT: begin
        rdata_d    = '0;
        rdata_d[1] = data_ready;
        rdata_d[0] = tbre & tsre;
      end
      default: rdata_d = ram1_data;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      rgn_q   <= R_RAM1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      // One extra cycle of store data after the strobe edge.
      hold_q  <= act && last && we_q;
      if (accept) begin
        rgn_q   <= rgn_d;
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (accept && rgn_d == R_COM_RSV && !req_we)
        rdata_q <= '0;
      else if (act && last && !we_q)
        rdata_q <= rdata_d;
    end
  end

  always_comb begin
    ram1_en = 1'b1;
    ram1_oe = 1'b1;
    ram1_we = 1'b1;
    ram2_en = 1'b1;
    ram2_oe = 1'b1;
    ram2_we = 1'b1;
    rdn     = 1'b1;
    wrn     = 1'b1;
    if (sel) begin
      ram1_en = (rgn_q != R_RAM1);
      ram2_en = (rgn_q != R_RAM2);
    end
    if (act) begin
      unique case (rgn_q)
        R_RAM1:
          if (we_q) ram1_we = 1'b0;
          else      ram1_oe = 1'b0;
        R_RAM2:
          if (we_q) ram2_we = 1'b0;
          else      ram2_oe = 1'b0;
        R_COM_DATA:
          if (we_q) wrn = 1'b0;
          else      rdn = 1'b0;
        default: ;
      endcase
    end
  end

  assign drv = we_q && (sel || hold_q);

  assign ram1_data = (drv && on_bus1(rgn_q)) ?
                     wdata_q : 'z;
  assign ram2_data = (drv && rgn_q == R_RAM2) ?
                     wdata_q : 'z;

  assign rsp_valid = (state_q == S_DONE);
  assign rsp_rdata = rdata_q;
  assign ram_addr  = addr_q;
  assign addr_src  = (rgn_q == R_RAM2);

endmodule
